prbs_gen_64_2v31_tx: RTL
========================

# prbs_gen_64_2v31_tx

Transmit-side 64-bit parallel PRBS31 generator (x^31 + x^28 + 1, XNOR feedback) that feeds the GTF MAC TX datapath with a continuous test pattern. It produces one 64-bit word per accepted transfer under a valid/ready handshake. The stream is bit-exact with the pattern that the receive-side PRBS31 checker locks to and predicts, and the same data ordering applies: MSB first. It also provides deterministic single-bit error injection and transfer counters for link and latency bring-up.

## Interface
- SEED, 31'h0000_0000, initial LFSR history. It holds s[-31..-1], with SEED[30] = s[-31]. 31'h7FFF_FFFF is the XNOR lock-up state; if supplied, the block substitutes 31'h0000_0000.
- C  in  1  clock (TX user clock)
- R  in  1  reset, synchronous, active-high
- enable  in  1  level; high starts/continues generation, low stops after the current handshake
- tx_ready  in  1  downstream accepts tx_data when tx_valid && tx_ready
- inject_err  in  1  single-cycle request to corrupt one upcoming word
- tx_data  out  64  PRBS word; tx_data[63] is the earliest bit in time
- tx_valid  out  1  tx_data valid
- tx_first  out  1  high with the first word after each (re)seed
- word_cnt  out  48  accepted words since last seed, wraps modulo 2^48
- err_cnt  out  16  injected errors since reset, saturates at 16'hFFFF

## Operation
- Serial definition: s[n] = s[n-31] XNOR s[n-28]. Word k carries s[64k .. 64k+63], with s[64k] on tx_data[63].
- Internal 31-bit state holds the last 31 bits emitted. The next word is computed combinationally from that state in a single cycle.
- States:
  - IDLE: tx_valid = 0. LFSR is loaded from SEED. On enable = 1, go to LOAD.
  - LOAD: compute word 0 into the output register, set tx_valid = 1 and tx_first = 1, clear word_cnt. Go to RUN.
  - RUN: on each accept (tx_valid && tx_ready), increment word_cnt and clear tx_first.
    - If enable = 1, load the next word in the same edge, so tx_valid stays 1.
    - If enable = 0, clear tx_valid and go to IDLE.
- enable low while tx_valid && !tx_ready: the word is held until it is accepted, then the block goes to IDLE. A word is never dropped or truncated.
- Re-enabling after IDLE reseeds, so the stream restarts at word 0 with tx_first = 1.
- Error injection:
  - inject_err sets a pending flag. The flag is applied to the next word loaded into the output register by inverting its bit 0.
  - The LFSR state is never corrupted, so the checker sees exactly one bit error.
  - err_cnt increments when the corrupted word is accepted.
  - Requests arriving while a flag is already pending are merged into that one flag.
  - inject_err in the same cycle as a word load applies to the following load.
  - The pending flag is cleared in IDLE.
- While tx_valid && !tx_ready: tx_data, tx_first and tx_valid are held stable, and the LFSR does not advance.

## Timing
- Reset values: tx_valid = 0, tx_first = 0, tx_data = 64'h0, word_cnt = 0, err_cnt = 0, state = IDLE, pending flag = 0. LFSR = SEED, or the substitute if SEED is the lock-up value.
- R asserted mid-stream takes effect at the next edge and overrides all other inputs. tx_valid drops in the following cycle without waiting for a handshake.
- Startup latency: enable sampled high at edge t gives LOAD at t+1 and tx_valid = 1 after edge t+1, which is 2 cycles.
- Throughput: with tx_ready held high, one word per cycle with no bubbles.
- Stop latency: when a word is accepted with enable = 0, tx_valid is 0 in the next cycle.
- word_cnt wraps from 2^48-1 to 0. err_cnt holds at 16'hFFFF.

## Test plan
- Reset, SEED = 0, enable = 1, tx_ready = 1 -> first word 64'hFFFFFFF1_FFFFFF03 with tx_first = 1, 2 cycles after enable. A following 10^6-word stream matches the serial model, and the receive-side checker reports 0 errors.
- Backpressure: toggle tx_ready randomly at 50% -> data is held stable while stalled, no words are skipped or duplicated, and word_cnt equals the number of accepts.
- inject_err pulsed at cycle 100 and again at cycle 101 -> exactly one word has bit 0 inverted versus the model, err_cnt = 1, and the next word matches the model.
- enable dropped during a stall -> the held word is accepted, tx_valid = 0 the next cycle, and state is IDLE. Re-enabling restarts at 64'hFFFFFFF1_FFFFFF03.
- SEED = 31'h7FFF_FFFF -> output is identical to SEED = 0, never all-ones lock-up.
- R asserted mid-RUN with tx_valid = 1 -> all outputs take reset values the next cycle. word_cnt preset near 2^48-1 in simulation wraps to 0 on the next accept.

Source files
------------

// File: rtl/prbs_gen_64_2v31_tx.sv
// 64-bit parallel PRBS31 (x^31 + x^28 + 1, XNOR) transmit generator with
// valid/ready output, single-bit error injection and transfer counters.
module prbs_gen_64_2v31_tx #(
  parameter logic [30:0] SEED = 31'h0000_0000
) (
  input  logic        C,
  input  logic        R,
  input  logic        enable,
  input  logic        tx_ready,
  input  logic        inject_err,
  output logic [63:0] tx_data,
  output logic        tx_valid,
  output logic        tx_first,
  output logic [47:0] word_cnt,
  output logic [15:0] err_cnt,
  output logic [1:0]  dbg_state
);

  // The all-ones history is the XNOR lock-up state; fall back to all-zeros.
  localparam logic [30:0] SEED_EFF = (SEED == 31'h7FFF_FFFF) ? 31'h0 : SEED;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [30:0] lfsr_q, lfsr_d;
  logic [63:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        first_q, first_d;
  logic [47:0] cnt_q, cnt_d;
  logic [15:0] errc_q, errc_d;
  logic        pend_q, pend_d;
  logic        cur_err_q, cur_err_d;

  logic [63:0] nxt_word;
  logic [30:0] nxt_lfsr;
  logic [30:0] hist;
  logic        fb;
  logic        load;
  logic        accept;

  // lfsr_q[30] is the oldest bit s[n-31], lfsr_q[0] the newest s[n-1].
  always_comb begin
    hist     = lfsr_q;
    fb       = 1'b0;
    nxt_word = '0;
    for (int i = 0; i < 64; i++) begin
      fb            = ~(hist[30] ^ hist[27]);
      nxt_word[63-i] = fb;
      hist          = {hist[29:0], fb};
    end
    nxt_lfsr = hist;
  end

  // Handshake: a word transfers on a rising edge where tx_valid && tx_ready;
  // while tx_valid is high and tx_ready low, data, first and LFSR are frozen.
  assign accept = valid_q & tx_ready;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    first_d   = first_q;
    cnt_d     = cnt_q;
    errc_d    = errc_q;
    cur_err_d = cur_err_q;
    pend_d    = pend_q | inject_err;
    load      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        lfsr_d  = SEED_EFF;
        pend_d  = 1'b0;
        valid_d = 1'b0;
        if (enable) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load    = 1'b1;
        first_d = 1'b1;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept) begin
          cnt_d   = cnt_q + 48'd1;
          first_d = 1'b0;
          if (cur_err_q && (errc_q != 16'hFFFF)) errc_d = errc_q + 16'd1;
          if (enable) begin
            load = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A request arriving while a flag is pending merges into it, so a load
    // only re-arms the flag for a request that was not already pending.
    if (load) begin
      data_d    = nxt_word ^ {63'b0, pend_q};
      cur_err_d = pend_q;
      lfsr_d    = nxt_lfsr;
      valid_d   = 1'b1;
      pend_d    = inject_err & ~pend_q;
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= SEED_EFF;
      data_q    <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      cnt_q     <= '0;
      errc_q    <= '0;
      pend_q    <= 1'b0;
      cur_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      errc_q    <= errc_d;
      pend_q    <= pend_d;
      cur_err_q <= cur_err_d;
    end
  end

  assign tx_data   = data_q;
  assign tx_valid  = valid_q;
  assign tx_first  = first_q;
  assign word_cnt  = cnt_q;
  assign err_cnt   = errc_q;
  assign dbg_state = state_q;

endmodule
